// File: rtl/fmul_param.sv
// Parametrised IEEE-754 multiplier with valid/ready handshakes. One operation
// is in flight at a time. The FSM walks it through unpack, special-case
// screening, subnormal normalisation, multiply, underflow alignment, rounding
// and packing. The result is then held until the consumer takes it.
module fmul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           rm,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [3:0]           flags,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;         // mantissa including hidden bit
  localparam int EW   = EXP_W + 2;         // signed exponent width, never wraps
  localparam int PW   = 2 * M;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int CW   = $clog2(MAN_W + 4);

  localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E  = EW'(BIAS + 1);   // field all ones
  localparam logic signed [EW-1:0] EZERO_E = EW'(-BIAS);      // field zero
  localparam logic signed [EW-1:0] EMIN_E  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] ONE_E   = EW'(1);
  localparam logic [CW-1:0]        SH_MAX  = CW'(MAN_W + 3);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM, S_MULT,
    S_ALIGN, S_ROUND, S_PACK, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]           a_q, a_d, b_q, b_d, z_q, z_d;
  logic [1:0]             rm_q, rm_d;
  logic [3:0]             flags_q, flags_d;
  logic                   sa_q, sa_d, sb_q, sb_d, zs_q, zs_d;
  logic signed [EW-1:0]   ea_q, ea_d, eb_q, eb_d, ze_q, ze_d;
  logic [MAN_W-1:0]       fa_q, fa_d, fb_q, fb_d;
  logic [M-1:0]           ma_q, ma_d, mb_q, mb_d, zm_q, zm_d;
  logic                   g_q, g_d, r_q, r_d, s_q, s_d, nx_q, nx_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [PW-1:0]          prod, prod_n;
  logic [M:0]             sum;
  logic                   inc, ovf_max;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub;

  assign a_nan  = (ea_q == EMAX_E) && (fa_q != '0);
  assign b_nan  = (eb_q == EMAX_E) && (fb_q != '0);
  assign a_inf  = (ea_q == EMAX_E) && (fa_q == '0);
  assign b_inf  = (eb_q == EMAX_E) && (fb_q == '0);
  assign a_sub  = (ea_q == EZERO_E);
  assign b_sub  = (eb_q == EZERO_E);
  assign a_zero = a_sub && (fa_q == '0);
  assign b_zero = b_sub && (fb_q == '0);

  assign prod = PW'(ma_q) * PW'(mb_q);
  assign sum  = {1'b0, zm_q} + {{M{1'b0}}, 1'b1};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign z         = z_q;
  assign flags     = flags_q;

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d = state_q;
    a_d = a_q;   b_d = b_q;   rm_d = rm_q;
    sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q;
    fa_d = fa_q; fb_d = fb_q; ma_d = ma_q; mb_d = mb_q;
    zs_d = zs_q; ze_d = ze_q; zm_d = zm_q;
    g_d = g_q;   r_d = r_q;   s_d = s_q;   nx_d = nx_q;
    cnt_d = cnt_q;
    z_d = z_q;   flags_d = flags_q;
    prod_n = prod;
    inc = 1'b0;
    ovf_max = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = a; b_d = b; rm_d = rm;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sa_d = a_q[W-1];
        sb_d = b_q[W-1];
        ea_d = $signed({2'b00, a_q[W-2:MAN_W]}) - BIAS_E;
        eb_d = $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS_E;
        fa_d = a_q[MAN_W-1:0];
        fb_d = b_q[MAN_W-1:0];
        state_d = S_SPECIAL;
      end

      S_SPECIAL: begin
        zs_d = sa_q ^ sb_q;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          flags_d = 4'b1000;
          state_d = S_OUT;
        end else if (a_inf || b_inf) begin
          z_d = {sa_q ^ sb_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0000;
          state_d = S_OUT;
        end else if (a_zero || b_zero) begin
          z_d = {sa_q ^ sb_q, {(W-1){1'b0}}};
          flags_d = 4'b0000;
          state_d = S_OUT;
        end else begin
          ma_d = {~a_sub, fa_q};
          mb_d = {~b_sub, fb_q};
          ea_d = a_sub ? EMIN_E : ea_q;
          eb_d = b_sub ? EMIN_E : eb_q;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (ma_q[M-1] && mb_q[M-1]) begin
          state_d = S_MULT;
        end else begin
          if (!ma_q[M-1]) begin
            ma_d = {ma_q[M-2:0], 1'b0};
            ea_d = ea_q - ONE_E;
          end
          if (!mb_q[M-1]) begin
            mb_d = {mb_q[M-2:0], 1'b0};
            eb_d = eb_q - ONE_E;
          end
        end
      end

      // A product below 2 is renormalised here so the common case costs no
      // extra ALIGN cycle; the shift is exact because it is taken from the
      // full product before guard/round/sticky are formed.
      S_MULT: begin
        if (prod[PW-1]) begin
          prod_n = prod;
          ze_d   = ea_q + eb_q + ONE_E;
        end else begin
          prod_n = {prod[PW-2:0], 1'b0};
          ze_d   = ea_q + eb_q;
        end
        zm_d  = prod_n[PW-1:M];
        g_d   = prod_n[M-1];
        r_d   = prod_n[M-2];
        s_d   = |prod_n[M-3:0];
        cnt_d = '0;
        state_d = S_ALIGN;
      end

      S_ALIGN: begin
        if ((ze_q < EMIN_E) && (cnt_q < SH_MAX)) begin
          zm_d  = {1'b0, zm_q[M-1:1]};
          g_d   = zm_q[0];
          r_d   = g_q;
          s_d   = s_q | r_q;
          ze_d  = ze_q + ONE_E;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        case (rm_q)
          RM_RNE:  inc = g_q & (r_q | s_q | zm_q[0]);
          RM_RUP:  inc = ~zs_q & (g_q | r_q | s_q);
          RM_RDN:  inc = zs_q & (g_q | r_q | s_q);
          default: inc = 1'b0;
        endcase
        if (inc) begin
          if (sum[M]) begin
            zm_d = sum[M:1];
            ze_d = ze_q + ONE_E;
          end else begin
            zm_d = sum[M-1:0];
          end
        end
        nx_d = g_q | r_q | s_q;
        state_d = S_PACK;
      end

      S_PACK: begin
        ovf_max = (rm_q == RM_RTZ) || ((rm_q == RM_RUP) && zs_q) ||
                  ((rm_q == RM_RDN) && !zs_q);
        if (ze_q > BIAS_E) begin
          z_d = ovf_max ? {zs_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                        : {zs_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (!zm_q[M-1]) begin
          z_d = {zs_q, {EXP_W{1'b0}}, zm_q[MAN_W-1:0]};
          flags_d = {2'b00, nx_q, nx_q};
        end else begin
          z_d = {zs_q, EXP_W'(ze_q + BIAS_E), zm_q[MAN_W-1:0]};
          flags_d = {3'b000, nx_q};
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the visible result, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  // Working datapath registers; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    a_q  <= a_d;  b_q  <= b_d;  rm_q <= rm_d;
    sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d;
    fa_q <= fa_d; fb_q <= fb_d; ma_q <= ma_d; mb_q <= mb_d;
    zs_q <= zs_d; ze_q <= ze_d; zm_q <= zm_d;
    g_q  <= g_d;  r_q  <= r_d;  s_q  <= s_d;  nx_q <= nx_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_fmul_param.sv
// Directed testbench for fmul_param: single precision plus a half-precision
// instance, covering specials, overflow, subnormals, rounding, backpressure
// and mid-operation reset.
module tb_fmul_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, z;
  logic [1:0]  rm;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  flags;

  logic [15:0] h_a, h_b, h_z;
  logic [1:0]  h_rm;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [3:0]  h_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmul_param #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .rm(rm),
    .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  fmul_param #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk(clk), .rst(rst), .a(h_a), .b(h_b), .rm(h_rm),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .z(h_z), .flags(h_flags), .out_valid(h_out_valid), .out_ready(h_out_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one operation with out_ready high; lat = edges after accept until out_valid.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                        output logic [31:0] rz, output logic [3:0] rf, output int lat);
    @(negedge clk);
    a = ta; b = tb; rm = trm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; rm = ~trm;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); lat++; #1;
    end
    if (out_valid) begin rz = z; rf = flags; end
    else begin rz = 'x; rf = 'x; lat = -1; end
    @(posedge clk); #1;
  endtask

  task automatic run_half(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] trm,
                          output logic [15:0] rz, output logic [3:0] rf, output int lat);
    @(negedge clk);
    h_a = ta; h_b = tb; h_rm = trm; h_in_valid = 1'b1; h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0; h_a = 16'hBEEF;
    lat = 0;
    while (!h_out_valid && lat < 300) begin
      @(posedge clk); lat++; #1;
    end
    if (h_out_valid) begin rz = h_z; rf = h_flags; end
    else begin rz = 'x; rf = 'x; lat = -1; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (z !== 32'h0) begin failures++; $display("FAIL reset_z got=%h exp=00000000", z); end
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h40400000, 32'h40000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h40C00000) begin failures++; $display("FAIL basic_z got=%h exp=40c00000", rz); end
    checks++; if (rf !== 4'h0) begin failures++; $display("FAIL basic_flags got=%h exp=0", rf); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL basic_latency got=%0d exp=7", lat); end
  endtask

  task automatic test_rounding();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h3F800001, 32'h3F800001, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h3F800002) begin failures++; $display("FAIL rne_below_half got=%h exp=3f800002", rz); end
    checks++; if (rf !== 4'h1) begin failures++; $display("FAIL rne_below_half_flags got=%h exp=1", rf); end
    run_op(32'h3F800001, 32'h3F800001, 2'b10, rz, rf, lat);
    checks++; if (rz !== 32'h3F800003) begin failures++; $display("FAIL rup_inexact got=%h exp=3f800003", rz); end
    run_op(32'h3FC00000, 32'h3F800001, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h3FC00002) begin failures++; $display("FAIL rne_tie_odd got=%h exp=3fc00002", rz); end
    run_op(32'h3FC00000, 32'h3F800001, 2'b01, rz, rf, lat);
    checks++; if (rz !== 32'h3FC00001) begin failures++; $display("FAIL rtz_tie got=%h exp=3fc00001", rz); end
    checks++; if (rf !== 4'h1) begin failures++; $display("FAIL rtz_tie_flags got=%h exp=1", rf); end
  endtask

  task automatic test_special();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h7F800000, 32'h00000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'hFFC00000) begin failures++; $display("FAIL inf_x_zero got=%h exp=ffc00000", rz); end
    checks++; if (rf !== 4'h8) begin failures++; $display("FAIL inf_x_zero_flags got=%h exp=8", rf); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL special_latency got=%0d exp=2", lat); end
    run_op(32'h7FC00001, 32'h3F800000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'hFFC00000) begin failures++; $display("FAIL nan_in got=%h exp=ffc00000", rz); end
    checks++; if (rf !== 4'h8) begin failures++; $display("FAIL nan_in_flags got=%h exp=8", rf); end
    run_op(32'h7F800000, 32'hC0000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'hFF800000) begin failures++; $display("FAIL inf_x_neg got=%h exp=ff800000", rz); end
    checks++; if (rf !== 4'h0) begin failures++; $display("FAIL inf_x_neg_flags got=%h exp=0", rf); end
    run_op(32'h00000000, 32'hC0000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h80000000) begin failures++; $display("FAIL zero_x_neg got=%h exp=80000000", rz); end
  endtask

  task automatic test_overflow();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h7F7FFFFF, 32'h40000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h7F800000) begin failures++; $display("FAIL ovf_rne got=%h exp=7f800000", rz); end
    checks++; if (rf !== 4'h5) begin failures++; $display("FAIL ovf_rne_flags got=%h exp=5", rf); end
    run_op(32'h7F7FFFFF, 32'h40000000, 2'b01, rz, rf, lat);
    checks++; if (rz !== 32'h7F7FFFFF) begin failures++; $display("FAIL ovf_rtz got=%h exp=7f7fffff", rz); end
    checks++; if (rf !== 4'h5) begin failures++; $display("FAIL ovf_rtz_flags got=%h exp=5", rf); end
    run_op(32'hFF7FFFFF, 32'h40000000, 2'b10, rz, rf, lat);
    checks++; if (rz !== 32'hFF7FFFFF) begin failures++; $display("FAIL ovf_rup_neg got=%h exp=ff7fffff", rz); end
    run_op(32'hFF7FFFFF, 32'h40000000, 2'b11, rz, rf, lat);
    checks++; if (rz !== 32'hFF800000) begin failures++; $display("FAIL ovf_rdn_neg got=%h exp=ff800000", rz); end
  endtask

  task automatic test_subnormal();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h00000001, 32'h4B000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h00800000) begin failures++; $display("FAIL sub_norm got=%h exp=00800000", rz); end
    checks++; if (rf !== 4'h0) begin failures++; $display("FAIL sub_norm_flags got=%h exp=0", rf); end
    checks++; if (lat !== 30) begin failures++; $display("FAIL sub_norm_latency got=%0d exp=30", lat); end
  endtask

  task automatic test_underflow();
    logic [31:0] rz; logic [3:0] rf; int lat;
    run_op(32'h00800000, 32'h3F000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h00400000) begin failures++; $display("FAIL uf_exact got=%h exp=00400000", rz); end
    checks++; if (rf !== 4'h0) begin failures++; $display("FAIL uf_exact_flags got=%h exp=0", rf); end
    run_op(32'h00800000, 32'h00800000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h00000000) begin failures++; $display("FAIL uf_rne got=%h exp=00000000", rz); end
    checks++; if (rf !== 4'h3) begin failures++; $display("FAIL uf_rne_flags got=%h exp=3", rf); end
    run_op(32'h00800000, 32'h00800000, 2'b10, rz, rf, lat);
    checks++; if (rz !== 32'h00000001) begin failures++; $display("FAIL uf_rup got=%h exp=00000001", rz); end
    checks++; if (rf !== 4'h3) begin failures++; $display("FAIL uf_rup_flags got=%h exp=3", rf); end
    run_op(32'h80800000, 32'h00800000, 2'b11, rz, rf, lat);
    checks++; if (rz !== 32'h80000001) begin failures++; $display("FAIL uf_rdn_neg got=%h exp=80000001", rz); end
  endtask

  task automatic test_half();
    logic [15:0] rz; logic [3:0] rf; int lat;
    run_half(16'h3C00, 16'h3C00, 2'b00, rz, rf, lat);
    checks++; if (rz !== 16'h3C00) begin failures++; $display("FAIL half_one got=%h exp=3c00", rz); end
    checks++; if (rf !== 4'h0) begin failures++; $display("FAIL half_one_flags got=%h exp=0", rf); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL half_latency got=%0d exp=7", lat); end
    run_half(16'h4200, 16'h4000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 16'h4600) begin failures++; $display("FAIL half_six got=%h exp=4600", rz); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rz; logic [3:0] rf; int lat;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40000000; rm = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); lat++; #1;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_result_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (z !== 32'h40C00000) begin failures++; $display("FAIL bp_z_hold got=%h exp=40c00000", z); end
      checks++; if (flags !== 4'h0) begin failures++; $display("FAIL bp_flags_hold got=%h exp=0", flags); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold got=%b exp=1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    run_op(32'h3F800000, 32'h40000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h40000000) begin failures++; $display("FAIL bp_next_op got=%h exp=40000000", rz); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rz; logic [3:0] rf; int lat;
    @(negedge clk);
    a = 32'h40400000; b = 32'h40000000; rm = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    checks++; if (z !== 32'h0) begin failures++; $display("FAIL midrst_z got=%h exp=00000000", z); end
    @(negedge clk); rst = 1'b1;
    run_op(32'h40400000, 32'h40000000, 2'b00, rz, rf, lat);
    checks++; if (rz !== 32'h40C00000) begin failures++; $display("FAIL midrst_next got=%h exp=40c00000", rz); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL midrst_latency got=%0d exp=7", lat); end
  endtask

  initial begin
    rst = 1'b0;
    a = '0; b = '0; rm = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
    h_a = '0; h_b = '0; h_rm = 2'b00; h_in_valid = 1'b0; h_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_overflow();
    test_subnormal();
    test_underflow();
    test_half();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
